// File: rtl/router_input_port.sv
// router_input_port: one input channel of the mesh NoC router.
// Buffers incoming flits in a small FIFO, computes the XY route of each
// packet's head flit, requests the switch allocator for the whole packet
// (wormhole), forwards flits while granted and returns one credit per flit.
// Optional build macro: ROUTER_INPUT_PORT_STATS_EN adds pkt_count_dout, a
// saturating count of packets (tail flits) forwarded.
module router_input_port #(
    parameter int CHANNEL_WIDTH = 32,
    parameter int BUFFER_DEPTH  = 4,
    parameter int X_LOCAL       = 2,
    parameter int Y_LOCAL       = 2,
    parameter int X_WIDTH       = 3,
    parameter int Y_WIDTH       = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNEL_WIDTH-1:0] channel_din,
    output logic                     credit_out_dout,
    output logic [4:0]               request_dout,
    input  logic                     grant_din,
    output logic [CHANNEL_WIDTH-1:0] flit_dout,
    output logic                     flit_valid_dout,
    output logic                     overflow_error_dout
`ifdef ROUTER_INPUT_PORT_STATS_EN
    ,
    output logic [15:0]              pkt_count_dout
`endif
);

    localparam int ADDR_W = $clog2(BUFFER_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    localparam logic [X_WIDTH-1:0] X_LOC = X_WIDTH'(X_LOCAL);
    localparam logic [Y_WIDTH-1:0] Y_LOC = Y_WIDTH'(Y_LOCAL);

    // Request encoding {pe, yneg, xneg, ypos, xpos}
    localparam logic [4:0] REQ_XPOS = 5'b00001;
    localparam logic [4:0] REQ_YPOS = 5'b00010;
    localparam logic [4:0] REQ_XNEG = 5'b00100;
    localparam logic [4:0] REQ_YNEG = 5'b01000;
    localparam logic [4:0] REQ_PE   = 5'b10000;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ROUTE  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    logic [CHANNEL_WIDTH-1:0] fifo_mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [1:0]               state;
    logic                     empty;
    logic                     full;
    logic                     push;
    logic                     pop;
    logic                     head_tail;
    logic [X_WIDTH-1:0]       dest_x;
    logic [Y_WIDTH-1:0]       dest_y;
    logic [4:0]               route_req;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    assign flit_dout       = fifo_mem[rd_ptr[ADDR_W-1:0]];
    assign pop             = (state == ACTIVE) && grant_din && !empty;
    assign flit_valid_dout = pop;
    assign push            = channel_din[CHANNEL_WIDTH-1] && (!full || pop);

    assign head_tail = flit_dout[CHANNEL_WIDTH-2];
    assign dest_x    = flit_dout[CHANNEL_WIDTH-3 -: X_WIDTH];
    assign dest_y    = flit_dout[CHANNEL_WIDTH-3-X_WIDTH -: Y_WIDTH];

    // XY dimension-order routing of the flit currently at the FIFO head.
    always_comb begin
        route_req = REQ_PE;
        if (dest_x > X_LOC) begin
            route_req = REQ_XPOS;
        end else if (dest_x < X_LOC) begin
            route_req = REQ_XNEG;
        end else if (dest_y > Y_LOC) begin
            route_req = REQ_YPOS;
        end else if (dest_y < Y_LOC) begin
            route_req = REQ_YNEG;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[ADDR_W-1:0]] <= channel_din;
        end
    end

    // FIFO pointers wrap naturally modulo twice the depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // One credit per forwarded flit, and a sticky flag for dropped flits.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_out_dout     <= 1'b0;
            overflow_error_dout <= 1'b0;
        end else begin
            credit_out_dout <= pop;
            if (channel_din[CHANNEL_WIDTH-1] && full && !pop) begin
                overflow_error_dout <= 1'b1;
            end
        end
    end

    // Packet tracking: route a new head, hold the request until the tail leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            request_dout <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= ROUTE;
                    end
                end
                ROUTE: begin
                    request_dout <= route_req;
                    state        <= ACTIVE;
                end
                ACTIVE: begin
                    if (pop && head_tail) begin
                        request_dout <= '0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    request_dout <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef ROUTER_INPUT_PORT_STATS_EN
    // Saturating count of packets whose tail flit has been forwarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_dout <= '0;
        end else if (pop && head_tail && (pkt_count_dout != 16'hFFFF)) begin
            pkt_count_dout <= pkt_count_dout + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_router_input_port.sv
// tb_router_input_port: bench for router_input_port (W=32, depth 4, node (2,2)).
// A queue-based reference model predicts control outputs every cycle; every
// flit it accepts is pushed to a scoreboard that a separate monitor drains
// whenever the DUT presents a flit. Build with ROUTER_INPUT_PORT_STATS_EN
// to also check the packet counter.
module tb_router_input_port;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int XW    = 3;
    localparam int YW    = 3;
    localparam int XL    = 2;
    localparam int YL    = 2;

    logic         clk;
    logic         reset;
    logic [W-1:0] channel_din;
    logic         credit_out_dout;
    logic [4:0]   request_dout;
    logic         grant_din;
    logic [W-1:0] flit_dout;
    logic         flit_valid_dout;
    logic         overflow_error_dout;
`ifdef ROUTER_INPUT_PORT_STATS_EN
    logic [15:0]  pkt_count_dout;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] sb_q[$];
    bit           m_fwd;
    int           m_age;
    logic [4:0]   m_req;
    bit           m_credit;
    bit           m_ovf;
    int           m_pkts;

    router_input_port #(
        .CHANNEL_WIDTH(W),
        .BUFFER_DEPTH (DEPTH),
        .X_LOCAL      (XL),
        .Y_LOCAL      (YL),
        .X_WIDTH      (XW),
        .Y_WIDTH      (YW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .channel_din        (channel_din),
        .credit_out_dout    (credit_out_dout),
        .request_dout       (request_dout),
        .grant_din          (grant_din),
        .flit_dout          (flit_dout),
        .flit_valid_dout    (flit_valid_dout),
        .overflow_error_dout(overflow_error_dout)
`ifdef ROUTER_INPUT_PORT_STATS_EN
        ,
        .pkt_count_dout     (pkt_count_dout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] make_flit(input bit v, input bit t,
                                               input int dx, input int dy,
                                               input logic [23:0] pl);
        logic [W-1:0] f;
        f = {v, t, 3'(dx), 3'(dy), pl};
        return f;
    endfunction

    // XY routing decided from the destination numbers themselves.
    function automatic logic [4:0] expect_route(input logic [W-1:0] f);
        int dx;
        int dy;
        dx = int'(f >> (W - 2 - XW)) % (1 << XW);
        dy = int'(f >> (W - 2 - XW - YW)) % (1 << YW);
        if (dx > XL) return 5'b00001;
        if (dx < XL) return 5'b00100;
        if (dy > YL) return 5'b00010;
        if (dy < YL) return 5'b01000;
        return 5'b10000;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compares this cycle's control outputs with the reference model.
    task automatic checkOutput();
        bit exp_valid;
        exp_valid = m_fwd && grant_din && (mq.size() > 0);
        checkValue("request", 32'(request_dout), 32'(m_req));
        checkValue("flit_valid", 32'(flit_valid_dout), 32'(exp_valid));
        checkValue("credit", 32'(credit_out_dout), 32'(m_credit));
        checkValue("overflow", 32'(overflow_error_dout), 32'(m_ovf));
`ifdef ROUTER_INPUT_PORT_STATS_EN
        checkValue("pkt_count", 32'(pkt_count_dout), 32'(m_pkts));
`endif
    endtask

    // Advances the reference model across the coming clock edge.
    task automatic modelStep(input logic [W-1:0] din, input bit grant, input bit rst);
        bit pop;
        bit push;
        bit tail_pop;
        pop  = m_fwd && grant && (mq.size() > 0);
        push = din[W-1] && ((mq.size() < DEPTH) || pop);
        if (rst) begin
            mq.delete();
            sb_q.delete();
            m_fwd    = 1'b0;
            m_age    = 0;
            m_req    = '0;
            m_credit = 1'b0;
            m_ovf    = 1'b0;
            m_pkts   = 0;
            return;
        end
        tail_pop = pop && mq[0][W-2];
        if (!m_fwd) begin
            if (mq.size() > 0) begin
                if (m_age == 1) begin
                    m_fwd = 1'b1;
                    m_req = expect_route(mq[0]);
                    m_age = 0;
                end else begin
                    m_age = 1;
                end
            end
        end else if (tail_pop) begin
            m_fwd = 1'b0;
            m_req = '0;
        end
        m_credit = pop;
        if (din[W-1] && !push) m_ovf = 1'b1;
        if (tail_pop && m_pkts < 65535) m_pkts++;
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(din);
            sb_q.push_back(din);
        end
    endtask

    // Drives one cycle of inputs, checks outputs, then steps the model.
    task automatic applyStimulus(input logic [W-1:0] din, input bit grant,
                                 input bit rst, input bit do_check);
        bit g;
        g = grant && !rst;
        @(posedge clk);
        #1;
        channel_din = din;
        grant_din   = g;
        reset       = rst;
        #2;
        if (do_check) checkOutput();
        modelStep(din, g, rst);
    endtask

    task automatic idle(input int n, input bit grant);
        for (int i = 0; i < n; i++) applyStimulus('0, grant, 1'b0, 1'b1);
    endtask

    // Monitor: every flit the DUT forwards must be the oldest accepted flit.
    initial begin
        logic [W-1:0] exp_flit;
        forever begin
            @(negedge clk);
            if (flit_valid_dout === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL flit_unexpected: got %h, expected no flit", flit_dout);
                end else begin
                    exp_flit = sb_q.pop_front();
                    checkValue("flit_data", flit_dout, exp_flit);
                end
            end
        end
    end

    initial begin
        logic [4:0] route_exp [4];
        int         route_dx [4];
        int         route_dy [4];

        channel_din = '0;
        grant_din   = 1'b0;
        reset       = 1'b1;
        m_fwd = 1'b0; m_age = 0; m_req = '0; m_credit = 1'b0; m_ovf = 1'b0; m_pkts = 0;

        $display("[TB] reset");
        applyStimulus('0, 1'b0, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b1, 1'b1);

        $display("[TB] single-flit packet to (2,2)");
        applyStimulus(make_flit(1, 1, 2, 2, 24'h000000), 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        checkValue("single_req_t2", 32'(request_dout), 32'h10);
        checkValue("single_valid_t2", 32'(flit_valid_dout), 32'h1);
        idle(1, 1'b1);
        checkValue("single_credit_t3", 32'(credit_out_dout), 32'h1);
        checkValue("single_req_cleared", 32'(request_dout), 32'h0);
        idle(3, 1'b1);

        $display("[TB] XY routing");
        route_dx = '{3, 1, 2, 2};
        route_dy = '{0, 3, 3, 1};
        route_exp = '{5'b00001, 5'b00100, 5'b00010, 5'b01000};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(make_flit(1, 1, route_dx[k], route_dy[k], 24'(k)), 1'b1, 1'b0, 1'b1);
            idle(3, 1'b1);
            checkValue("route_dir", 32'(request_dout), 32'(route_exp[k]));
            idle(3, 1'b1);
        end

        $display("[TB] 3-flit wormhole with delayed grant");
        applyStimulus(make_flit(1, 0, 3, 2, 24'hAAAA01), 1'b0, 1'b0, 1'b1);
        applyStimulus(make_flit(1, 0, 0, 0, 24'hAAAA02), 1'b0, 1'b0, 1'b1);
        applyStimulus(make_flit(1, 1, 0, 0, 24'hAAAA03), 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        checkValue("worm_req_held", 32'(request_dout), 32'h01);
        idle(6, 1'b1);

        $display("[TB] overflow");
        applyStimulus('0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++)
            applyStimulus(make_flit(1, 0, 3, 2, 24'(16 + k)), 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        checkValue("ovf_set", 32'(overflow_error_dout), 32'h1);
        idle(6, 1'b1);
        applyStimulus(make_flit(1, 1, 0, 0, 24'h0000FF), 1'b1, 1'b0, 1'b1);
        idle(4, 1'b1);
        checkValue("ovf_sticky", 32'(overflow_error_dout), 32'h1);

        $display("[TB] full FIFO with simultaneous push and pop");
        applyStimulus('0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++)
            applyStimulus(make_flit(1, 0, 1, 1, 24'(32 + k)), 1'b0, 1'b0, 1'b1);
        applyStimulus(make_flit(1, 0, 1, 1, 24'h000099), 1'b1, 1'b0, 1'b1);
        idle(2, 1'b0);
        checkValue("full_pushpop_no_ovf", 32'(overflow_error_dout), 32'h0);
        idle(6, 1'b1);
        applyStimulus(make_flit(1, 1, 1, 1, 24'h0000AB), 1'b1, 1'b0, 1'b1);
        idle(4, 1'b1);

        $display("[TB] reset mid-packet");
        applyStimulus(make_flit(1, 0, 0, 2, 24'h000101), 1'b0, 1'b0, 1'b1);
        applyStimulus(make_flit(1, 0, 0, 0, 24'h000102), 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        checkValue("midpkt_req_before", 32'(request_dout), 32'h04);
        applyStimulus('0, 1'b0, 1'b1, 1'b1);
        applyStimulus('0, 1'b1, 1'b0, 1'b1);
        checkValue("midpkt_req_cleared", 32'(request_dout), 32'h0);
        checkValue("midpkt_no_flit", 32'(flit_valid_dout), 32'h0);
        checkValue("midpkt_no_credit", 32'(credit_out_dout), 32'h0);
        idle(3, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] f;
            bit           g;
            bit           r;
            f = make_flit($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          24'($urandom));
            g = $urandom_range(0, 9) < 7;
            r = $urandom_range(0, 199) == 0;
            applyStimulus(f, g, r, 1'b1);
        end
        idle(12, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
